// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for logic_unit_arbiter.
// resp_zero exists only when LOGIC_ARB_ZERO_FLAG_EN is defined.
interface logic_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0][1:0]       req_op;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [WIDTH-1:0]              resp_data;
  logic [ID_W-1:0]               resp_id;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  logic                          resp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_zero
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_zero
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
`endif
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one bitwise logic unit (AND/OR/XOR/NAND) among NUM_REQ requesters.
// Optional zero flag on the response: define LOGIC_ARB_ZERO_FLAG_EN.

module logic_unit_arbiter_lu #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    unique case (op)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b;
      default: y = ~(a & b);
    endcase
  end
endmodule

module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int ID_W    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_unit_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  idx;
  logic             grant_vld;
  logic [WIDTH-1:0] lu_y;

  // Rotating search starting just after the previous winner.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_vld && bus.req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  // Held low during reset so no requester sees a phantom accept.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state == IDLE && grant_vld) bus.req_ready[grant] = 1'b1;
  end

  logic_unit_arbiter_lu #(.WIDTH(WIDTH)) u_lu (
    .a  (bus.req_a[grant]),
    .b  (bus.req_b[grant]),
    .op (bus.req_op[grant]),
    .y  (lu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= ID_W'(NUM_REQ - 1);
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      bus.resp_zero  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (grant_vld) begin
          bus.resp_data  <= lu_y;
          bus.resp_id    <= grant;
          last_grant     <= grant;
          bus.resp_valid <= 1'b1;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
          bus.resp_zero  <= (lu_y == '0);
`endif
          state          <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_logic_unit_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();
  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // model: one outstanding response, plus who won last
  bit          m_busy = 1'b0;
  logic [W-1:0] m_data = '0;
  int          m_id   = 0;
  int          m_last = N - 1;

  logic [N-1:0] exp_rdy;
  int           cg;
  int           mg;

  function automatic logic [W-1:0] lop(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else if (!m_busy) begin
      mg = pick(bus.req_valid, m_last);
      if (mg >= 0) begin
        m_busy = 1'b1;
        m_data = lop(bus.req_a[mg], bus.req_b[mg], bus.req_op[mg]);
        m_id   = mg;
        m_last = mg;
      end
    end else if (bus.resp_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_rdy = '0;
      if (rst_n && !m_busy) begin
        cg = pick(bus.req_valid, m_last);
        if (cg >= 0) exp_rdy[cg] = 1'b1;
      end
      check("req_ready", bus.req_ready, exp_rdy);
      check("resp_valid", bus.resp_valid, m_busy);
      if (m_busy) begin
        check("resp_data", bus.resp_data, m_data);
        check("resp_id", bus.resp_id, m_id);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        check("resp_zero", bus.resp_zero, m_data == '0);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic solo(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic rr);
    bus.req_valid     = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_a[id]     = a;
    bus.req_b[id]     = b;
    bus.req_op[id]    = op;
    bus.resp_ready    = rr;
  endtask

  // Single request from requester id; checks same-cycle ready and the result literal.
  task automatic one_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [W-1:0] exp);
    logic [N-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    tick();
    solo(id, a, b, op, 1'b1);
    @(negedge clk);
    check("op_ready", bus.req_ready, oh);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("op_valid", bus.resp_valid, 1'b1);
    check("op_data", bus.resp_data, exp);
    check("op_id", bus.resp_id, id);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    check("op_zero", bus.resp_zero, exp == '0);
`endif
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b1;
    #23;
    check("rst_valid", bus.resp_valid, 1'b0);
    check("rst_data", bus.resp_data, '0);
    check("rst_id", bus.resp_id, '0);
    check("rst_ready", bus.req_ready, '0);
    tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // AND example, then the op table on AAAA.../FFFF...
    one_op(0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00, 64'h0F0F_0000_0F0F_0000);
    one_op(1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    one_op(2, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'h5555_5555_5555_5555);
    one_op(3, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 64'h5555_5555_5555_5555);
    one_op(0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'hAAAA_AAAA_AAAA_AAAA);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    one_op(0, 64'hF0, 64'h0F, 2'b00, 64'h0);
    one_op(0, 64'hF0, 64'h0F, 2'b01, 64'hFF);
`endif

    // Fairness from reset: all valid, responses every other cycle.
    tick();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i]  = {$urandom, $urandom};
      bus.req_b[i]  = {$urandom, $urandom};
      bus.req_op[i] = 2'(i);
    end
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    rst_n          = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("rr_valid", bus.resp_valid, 1'b1);
      check("rr_id", bus.resp_id, j % N);
      @(negedge clk);
      check("rr_gap", bus.resp_valid, 1'b0);
    end

    // Back-pressure: response held for 10 cycles while everyone else waits.
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    solo(2, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0);
    @(negedge clk);
    check("bp_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '1;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", bus.resp_valid, 1'b1);
      check("bp_data", bus.resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
      check("bp_id", bus.resp_id, 2);
      check("bp_noacc", bus.req_ready, '0);
    end
    tick();
    bus.resp_ready = 1'b1;
    bus.req_valid  = '0;
    @(negedge clk);
    check("bp_hold", bus.resp_valid, 1'b1);
    @(negedge clk);
    check("bp_release", bus.resp_valid, 1'b0);

    // Reset while a response is pending.
    tick();
    solo(3, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 2'b10, 1'b0);
    tick();
    @(negedge clk);
    check("ar_pending", bus.resp_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", bus.resp_valid, 1'b0);
    check("ar_data", bus.resp_data, '0);
    check("ar_id", bus.resp_id, '0);
    check("ar_ready", bus.req_ready, '0);
    tick();
    tick();
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    rst_n          = 1'b1;
    @(negedge clk);
    check("ar_first", bus.req_ready, 4'b0001);

    // Random traffic with withdrawals, back-pressure and occasional resets.
    repeat (3000) begin
      tick();
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.req_a[i]  = {$urandom, $urandom};
        bus.req_b[i]  = ($urandom_range(0, 3) == 0) ? ~bus.req_a[i] : {$urandom, $urandom};
        bus.req_op[i] = 2'($urandom);
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      rst_n          = ($urandom_range(0, 199) != 0);
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
